// File: rtl/pulse_generator_pkg.sv
// Shared peripheral definitions for the pulse generator: FSM encodings and
// register address map.
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pg_state_t;

  localparam logic ADDR_WIDTH  = 1'b0;
  localparam logic ADDR_PERIOD = 1'b1;

endpackage

// File: rtl/pulse_generator.sv
// Bus-programmed pulse generator: one-shot or continuous pulse train with a
// sticky completion interrupt raised on every falling edge of pulse_out.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic                 i_addr,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_repeat_en,
  input  logic                 i_int_clr,
  output logic                 o_pulse_out,
  output logic                 o_busy,
  output logic                 o_int
);

  localparam logic [BUS_WIDTH-1:0] ONE = BUS_WIDTH'(1);

  pg_state_t            r_state;
  logic [BUS_WIDTH-1:0] r_width;
  logic [BUS_WIDTH-1:0] r_period;
  logic [BUS_WIDTH-1:0] r_w;
  logic [BUS_WIDTH-1:0] r_p;
  logic                 r_rep;
  logic [BUS_WIDTH-1:0] r_cnt;
  logic                 r_pulse;
  logic                 r_busy;
  logic                 r_int;

  logic [BUS_WIDTH-1:0] w_low_len;
  logic                 w_width_ok;

  // Low time is Pe-W; when P<=W the effective period is W+1 (saturating for
  // an all-ones W), which always leaves exactly one low cycle.
  assign w_low_len  = (r_p > r_w) ? (r_p - r_w) : ONE;
  assign w_width_ok = (r_width != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_width  <= '0;
      r_period <= '0;
      r_w      <= '0;
      r_p      <= '0;
      r_rep    <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_int    <= 1'b0;
    end else begin
      if (i_we) begin
        if (i_addr == ADDR_WIDTH) r_width  <= i_wdata;
        else                      r_period <= i_wdata;
      end

      // Any set below is a later assignment and therefore wins over the clear.
      if (i_int_clr) r_int <= 1'b0;

      if (i_stop) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else if (i_start && w_width_ok) begin
        // Launch or retrigger; a zero width start is ignored in every state.
        r_state <= ST_HIGH;
        r_w     <= r_width;
        r_p     <= r_period;
        r_rep   <= i_repeat_en;
        r_cnt   <= r_width;
        r_pulse <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_HIGH: begin
            if (r_cnt == ONE) begin
              r_int   <= 1'b1;
              r_pulse <= 1'b0;
              if (r_rep) begin
                r_state <= ST_LOW;
                r_cnt   <= w_low_len;
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          ST_LOW: begin
            if (r_cnt == ONE) begin
              r_w   <= r_width;
              r_p   <= r_period;
              r_rep <= i_repeat_en;
              if (i_repeat_en && w_width_ok) begin
                r_state <= ST_HIGH;
                r_cnt   <= r_width;
                r_pulse <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_pulse_out = r_pulse;
  assign o_busy      = r_busy;
  assign o_int       = r_int;

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Bus-programmed pulse generator: software writes a pulse width and period, then triggers one pulse or a continuous train on `pulse_out`, with a completion interrupt. It is the transmit-side companion to the pulse-capture peripheral: a width written here and looped back into a capture unit reads back as the same cycle count. It sits on the same peripheral bus and can feed a capture input directly for self-test.

## Interface
- `BUS_WIDTH`, 32, width of data bus, width/period registers and counter
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `we`  in  1  register write strobe, sampled on rising `clk`
- `addr`  in  1  register select: 0 = WIDTH, 1 = PERIOD
- `wdata`  in  BUS_WIDTH  write data
- `start`  in  1  launch/retrigger pulse generation (level-sampled, one cycle expected)
- `stop`  in  1  abort generation immediately
- `repeat_en`  in  1  0 = one-shot, 1 = continuous train; sampled at `start` and at each period boundary
- `int_clr`  in  1  clear interrupt flag
- `pulse_out`  out  1  generated pulse, registered
- `busy`  out  1  high while not IDLE
- `int`  out  1  interrupt flag, set on every pulse falling edge

## Operation
- Registers WIDTH and PERIOD reset to 0. A write with `we`=1 updates the register at the next edge. Writes are allowed while busy.
- At `start`, WIDTH and PERIOD are copied into active shadows W and P. In repeat mode, the shadows are reloaded at each period boundary.
- Effective period Pe = P if P > W, else W+1, so the low time is at least 1 cycle.
- FSM states:
  - IDLE (reset state).
    - `start` with WIDTH=0 is ignored: no state change, no `int`.
    - `start` with WIDTH>=1 goes to HIGH.
  - HIGH: `pulse_out`=1 for exactly W cycles.
    - At the end, `int` is set.
    - If repeat is off, go to IDLE.
    - Otherwise go to LOW.
  - LOW: `pulse_out`=0 for Pe−W cycles.
    - At the end, reload the shadows and re-sample `repeat_en`.
    - If `repeat_en`=1 and the reloaded W>=1, go to HIGH.
    - Otherwise go to IDLE.
- Counter: BUS_WIDTH-bit down-counter loaded with W (entering HIGH) or Pe−W (entering LOW). It transitions when the count reaches 1.
  - Pe−W is computed at BUS_WIDTH bits.
  - For W = all-ones with P<=W, the W+1 overflow is saturated so the low time is 1 cycle.
- Priority per cycle: `rst` > `stop` > `start` > normal sequencing.
  - `stop`: go to IDLE, `pulse_out`=0 at the next edge, no `int` set, counter cleared.
  - `start` while busy is a retrigger: shadows reloaded, go to HIGH, counter reloaded. If already high, `pulse_out` stays high with no glitch.
- `int` set vs `int_clr`:
  - A set event wins over `int_clr` in the same cycle.
  - `int_clr` alone clears `int` at the next edge.
  - `int_clr` does not affect the FSM.
- Reset mid-pulse: all state is cleared asynchronously and `pulse_out` drops immediately.

## Timing
- Reset values: `pulse_out`=0, `busy`=0, `int`=0, state IDLE, WIDTH=PERIOD=0.
- `start` sampled at edge N:
  - `pulse_out`=1 and `busy`=1 from edge N.
  - `pulse_out` falls at edge N+W, and `int` rises at the same edge N+W.
- One-shot: `busy` falls at edge N+W.
- Repeat: rising edges at N, N+Pe, N+2Pe, …; `int` is set at N+kPe+W.
- `stop` at edge M: `pulse_out`=0 and `busy`=0 from edge M.
- A register write at edge M is visible to a `start` sampled at edge M+1 or later. A write and `start` at the same edge use the old value.

## Structure
- Shared peripheral package: FSM state encodings (IDLE, HIGH, LOW) and the register address constants ADDR_WIDTH=0 and ADDR_PERIOD=1.
- Single module. The counter and Pe computation stay inline; no sub-module is warranted.

## Test plan
- One-shot: WIDTH=5, `start` at edge 10 -> `pulse_out` high at edges 10–14, low at 15; `int` set at 15; `busy` low at 15; `int_clr` at 20 clears `int` at 21.
- Repeat: WIDTH=3, PERIOD=8, `repeat_en`=1 -> rising edges every 8 cycles, 3 high / 5 low. Clearing `repeat_en` mid-train ends after the current period with `busy`=0.
- Degenerate cases:
  - WIDTH=0 with `start` -> no pulse, `busy` stays 0, no `int`.
  - WIDTH=4, PERIOD=2 in repeat -> 4 high / 1 low.
- Retrigger and stop:
  - `start` 2 cycles into a WIDTH=6 pulse -> `pulse_out` stays high 8 cycles total, no glitch.
  - `stop` mid-pulse -> low next edge, no `int`.
- Simultaneity: `int_clr` on the same edge as a falling edge -> `int`=1. Write WIDTH=9 during a repeat train of WIDTH=3 -> the next period uses 9.
- Reset: assert `rst` asynchronously mid-HIGH -> `pulse_out`, `busy` and `int` drop to 0 before the next clock edge; registers read back as 0 in effect (a later `start` is ignored).
